// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiplier, restoring divider.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle multiply.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*XLEN-1:0]  prod_q;
    logic [XLEN-1:0]    opnd_q;
    logic [1:0]         op_q;
    logic               neg_q;
    logic               rneg_q;
    logic               busy_q;
    logic               done_q;
    logic [XLEN-1:0]    result_q;

    logic               a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]    a_mag, b_mag;
    logic               b_zero, div_ovf, special;
    logic [XLEN-1:0]    spec_res;

    always_comb begin
        a_sgn    = op[2] ? ~op[0] : (op[1] ^ op[0]);
        b_sgn    = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        a_neg    = a_sgn & a[XLEN-1];
        b_neg    = b_sgn & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        b_zero   = (b == '0);
        div_ovf  = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
        special  = op[2] & (b_zero | div_ovf);
        if (b_zero) begin
            spec_res = op[1] ? a : '1;
        end else begin
            spec_res = op[1] ? '0 : a;
        end
    end

    // Divide step: prod_q holds {remainder, dividend/quotient}, opnd_q the divisor magnitude.
    logic [XLEN:0]      div_shift, div_diff;
    logic               div_ge;
    logic [2*XLEN-1:0]  div_next;
    logic [XLEN-1:0]    quo, rem, div_res;
    logic [2*XLEN-1:0]  mul_full;
    logic [XLEN-1:0]    mul_res;

    always_comb begin
        div_shift = prod_q[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     prod_q[XLEN-2:0], div_ge};
        quo       = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        if (op_q[1]) begin
            div_res = rneg_q ? -rem : rem;
        end else begin
            div_res = neg_q ? -quo : quo;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Operands are captured raw; signedness is re-derived from the stored funct3.
    logic                   a_sgn_q, b_sgn_q;
    logic signed [2*XLEN+1:0] fast_a, fast_b, fast_p;

    always_comb begin
        a_sgn_q  = op_q[1] ^ op_q[0];
        b_sgn_q  = (op_q == 2'b01);
        fast_a   = {{(XLEN+2){a_sgn_q & opnd_q[XLEN-1]}}, opnd_q};
        fast_b   = {{(XLEN+2){b_sgn_q & prod_q[XLEN-1]}}, prod_q[XLEN-1:0]};
        fast_p   = fast_a * fast_b;
        mul_full = fast_p[2*XLEN-1:0];
        mul_res  = (op_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
`else
    // Multiply step: low half of prod_q is the shifting multiplier, high half the partial sum.
    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
        mul_full = neg_q ? -mul_next : mul_next;
        mul_res  = (op_q == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q <= op[1:0];
                        if (special) begin
                            result_q <= spec_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (op[2]) begin
                            opnd_q  <= b_mag;
                            prod_q  <= {{XLEN{1'b0}}, a_mag};
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            cnt_q   <= CW'(XLEN);
                            busy_q  <= 1'b1;
                            state_q <= S_DIV;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            opnd_q  <= a;
                            prod_q  <= {{XLEN{1'b0}}, b};
`else
                            opnd_q  <= a_mag;
                            prod_q  <= {{XLEN{1'b0}}, b_mag};
                            neg_q   <= a_neg ^ b_neg;
`endif
                            cnt_q   <= CW'(XLEN);
                            busy_q  <= 1'b1;
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    result_q <= mul_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
`else
                    prod_q <= mul_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= mul_res;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
`endif
                end
                S_DIV: begin
                    prod_q <= div_next;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= div_res;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
